// File: rtl/finv_arbiter.sv
// finv_arbiter: round-robin sharing of one pipelined reciprocal unit between two requesters,
// with a tag pipeline that routes each result back to its issuer.
module finv_arbiter #(
  parameter int LATENCY = 3,
  parameter int CW      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] op0,
  input  logic [31:0] op1,
  output logic        gnt0,
  output logic        gnt1,
  input  logic        stall,
  output logic [31:0] finv_a,
  input  logic [31:0] finv_s,
  output logic [31:0] res_data,
  output logic        res0_valid,
  output logic        res1_valid,
  output logic        pend0,
  output logic        pend1,
  output logic        idle
);
  logic               r_last;
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_tag;
  logic [CW-1:0]      r_cnt0;
  logic [CW-1:0]      r_cnt1;
  logic               w_en;
  always_comb begin
    w_en       = rst_n & ~stall;
    gnt0       = w_en & req0 & (~req1 | r_last);
    gnt1       = w_en & req1 & (~req0 | ~r_last);
    finv_a     = gnt0 ? op0 : gnt1 ? op1 : 32'h0;
    res_data   = finv_s;
    res0_valid = r_vld[LATENCY-1] & ~r_tag[LATENCY-1];
    res1_valid = r_vld[LATENCY-1] & r_tag[LATENCY-1];
    pend0      = r_cnt0 != '0;
    pend1      = r_cnt1 != '0;
    idle       = ~pend0 & ~pend1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_vld  <= '0;
      r_tag  <= '0;
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (gnt0 | gnt1) r_last <= gnt1;
      r_vld[0] <= gnt0 | gnt1;
      r_tag[0] <= gnt1;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      // a grant and a retiring result in the same cycle cancel out
      r_cnt0 <= r_cnt0 + CW'(gnt0) - CW'(res0_valid);
      r_cnt1 <= r_cnt1 + CW'(gnt1) - CW'(res1_valid);
    end
  end
endmodule

// File: tb/tb_finv_arbiter.sv
// tb_finv_arbiter: table-driven check of grants, operand steering, result routing and pend/idle,
// with a 3-stage behavioural reciprocal unit on the finv port.
module tb_finv_arbiter;
  localparam logic [31:0] A = 32'h40000000, RA = 32'h3F000000;
  localparam logic [31:0] B = 32'h40800000, RB = 32'h3E800000;
  localparam logic [31:0] C = 32'h3F000000, RC = 32'h40000000;
  localparam logic [31:0] D = 32'h3F800000, RD = 32'h3F800000;

  typedef struct {
    logic r0, r1, st, rn;
    logic [31:0] op0, op1;
    logic g0, g1, v0, v1, p0, p1, id;
    logic [31:0] fa, rd;
  } vec_t;

  logic clk = 0, rst_n = 0, req0 = 0, req1 = 0, stall = 0;
  logic [31:0] op0 = 0, op1 = 0, finv_s;
  logic gnt0, gnt1, res0_valid, res1_valid, pend0, pend1, idle;
  logic [31:0] finv_a, res_data;
  logic [31:0] p_0 = 0, p_1 = 0, p_2 = 0;
  int n_run = 0, n_fail = 0;
  vec_t tv[$];

  finv_arbiter #(.LATENCY(3), .CW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .stall(stall), .finv_a(finv_a), .finv_s(finv_s),
    .res_data(res_data), .res0_valid(res0_valid), .res1_valid(res1_valid),
    .pend0(pend0), .pend1(pend1), .idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] recip(input logic [31:0] x);
    case (x)
      A: return RA;
      B: return RB;
      C: return RC;
      D: return RD;
      default: return ~x;
    endcase
  endfunction

  always @(posedge clk) begin
    p_0 <= recip(finv_a);
    p_1 <= p_0;
    p_2 <= p_1;
  end
  assign finv_s = p_2;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic v(input logic r0, r1, st, rn, input logic [31:0] o0, o1,
                   input logic g0, g1, v0, v1, p0, p1, id, input logic [31:0] rd);
    vec_t t;
    t = '{r0, r1, st, rn, o0, o1, g0, g1, v0, v1, p0, p1, id, 32'h0, rd};
    t.fa = g0 ? o0 : g1 ? o1 : 32'h0;
    tv.push_back(t);
  endtask

  initial begin
    int e[12] = '{0, 1, 2, 3, 3, 3, 3, 3, 3, 2, 1, 0};
    // single issue
    v(1,1,0,0,A,B, 0,0,0,0,0,0,1,0);
    v(1,0,0,1,A,0, 1,0,0,0,0,0,1,0);
    v(0,0,0,1,0,0, 0,0,0,0,1,0,0,0);
    v(0,0,0,1,0,0, 0,0,0,0,1,0,0,0);
    v(0,0,0,1,0,0, 0,0,1,0,1,0,0,RA);
    v(0,0,0,0,0,0, 0,0,0,0,0,0,1,0);
    // round robin from fresh reset
    v(1,1,0,1,A,B, 1,0,0,0,0,0,1,0);
    v(1,1,0,1,A,B, 0,1,0,0,1,0,0,0);
    v(1,1,0,1,A,B, 1,0,0,0,1,1,0,0);
    v(1,1,0,1,A,B, 0,1,1,0,1,1,0,RA);
    v(1,1,0,1,A,B, 1,0,0,1,1,1,0,RB);
    v(1,1,0,1,A,B, 0,1,1,0,1,1,0,RA);
    v(0,0,0,1,0,0, 0,0,0,1,1,1,0,RB);
    v(0,0,0,1,0,0, 0,0,1,0,1,1,0,RA);
    v(0,0,0,1,0,0, 0,0,0,1,0,1,0,RB);
    // stall in third cycle of contention
    v(1,1,0,1,C,D, 1,0,0,0,0,0,1,0);
    v(1,1,0,1,C,D, 0,1,0,0,1,0,0,0);
    v(1,1,1,1,C,D, 0,0,0,0,1,1,0,0);
    v(1,1,0,1,C,D, 1,0,1,0,1,1,0,RC);
    v(1,1,0,1,C,D, 0,1,0,1,1,1,0,RD);
    v(0,0,0,1,0,0, 0,0,0,0,1,1,0,0);
    v(0,0,0,1,0,0, 0,0,1,0,1,1,0,RC);
    v(0,0,0,1,0,0, 0,0,0,1,0,1,0,RD);
    v(0,0,0,1,0,0, 0,0,0,0,0,0,1,0);
    // reset mid-flight
    v(1,0,0,1,A,0, 1,0,0,0,0,0,1,0);
    v(0,1,0,1,0,B, 0,1,0,0,1,0,0,0);
    v(1,1,0,0,A,B, 0,0,0,0,1,1,0,0);
    v(1,1,0,1,A,B, 1,0,0,0,0,0,1,0);
    v(0,0,0,1,0,0, 0,0,0,0,1,0,0,0);
    v(0,0,0,1,0,0, 0,0,0,0,1,0,0,0);
    v(0,0,0,1,0,0, 0,0,1,0,1,0,0,RA);
    v(0,0,0,1,0,0, 0,0,0,0,0,0,1,0);
    // requester 1 alone
    v(0,1,0,1,0,B, 0,1,0,0,0,0,1,0);
    v(0,1,0,1,0,B, 0,1,0,0,0,1,0,0);
    v(0,1,0,1,0,B, 0,1,0,0,0,1,0,0);
    v(0,1,0,1,0,B, 0,1,0,1,0,1,0,RB);
    v(0,1,0,1,0,B, 0,1,0,1,0,1,0,RB);
    v(0,0,0,1,0,0, 0,0,0,1,0,1,0,RB);
    v(0,0,0,1,0,0, 0,0,0,1,0,1,0,RB);
    v(0,0,0,1,0,0, 0,0,0,1,0,1,0,RB);
    v(0,0,0,1,0,0, 0,0,0,0,0,0,1,0);

    rst_n = 0;
    repeat (2) @(posedge clk);
    foreach (tv[i]) begin
      @(negedge clk);
      {req0, req1, stall, rst_n, op0, op1} = {tv[i].r0, tv[i].r1, tv[i].st, tv[i].rn, tv[i].op0, tv[i].op1};
      #1;
      chk($sformatf("c%0d gnt0", i), 32'(gnt0), 32'(tv[i].g0));
      chk($sformatf("c%0d gnt1", i), 32'(gnt1), 32'(tv[i].g1));
      chk($sformatf("c%0d finv_a", i), finv_a, tv[i].fa);
      chk($sformatf("c%0d res0_valid", i), 32'(res0_valid), 32'(tv[i].v0));
      chk($sformatf("c%0d res1_valid", i), 32'(res1_valid), 32'(tv[i].v1));
      chk($sformatf("c%0d pend0", i), 32'(pend0), 32'(tv[i].p0));
      chk($sformatf("c%0d pend1", i), 32'(pend1), 32'(tv[i].p1));
      chk($sformatf("c%0d idle", i), 32'(idle), 32'(tv[i].id));
      if (tv[i].v0 | tv[i].v1) chk($sformatf("c%0d res_data", i), res_data, tv[i].rd);
    end
    chk("last after monopoly", 32'(dut.r_last), 32'd1);

    // requester 0 continuous: counter saturates where grant and result coincide, then drains
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req0 = (k < 8);
      op0 = D;
      #1;
      chk($sformatf("cnt0 k%0d", k), 32'(dut.r_cnt0), 32'(e[k]));
      chk($sformatf("gnt0 k%0d", k), 32'(gnt0), 32'(k < 8));
      chk($sformatf("res0_valid k%0d", k), 32'(res0_valid), 32'(k >= 3 && k < 11));
    end
    chk("last after req0 run", 32'(dut.r_last), 32'd0);
    chk("idle at end", 32'(idle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
